// File: rtl/seven_segment_counter_mux.sv
// Multi-digit BCD up/down seconds counter with prescaler, preload and a time-multiplexed seven-segment scan driver.
// Latency: bcd_out/wrap update on the edge after a step or load; led_out/digit_sel are registered 1 cycle from scan index and digits.
// Backpressure: none; free-running display driver, enable only gates the prescaler and count.
//
// Ports:
//   clk, reset (async, active-low)
//   enable     - prescaler runs while high; count and prescaler hold while low
//   up_down    - 1 counts up, 0 counts down
//   load       - synchronous preload of load_value (nibbles above 9 clamp to 9)
//   load_value - BCD preload, digit i at [4i+3:4i]
//   led_out    - segments {g,f,e,d,c,b,a} of the digit being scanned
//   digit_sel  - one-hot active-high digit enable
//   bcd_out    - current count, BCD
//   wrap       - one-cycle pulse when the count rolls over (99..9 -> 0 or 0 -> 99..9)
module seven_segment_counter_mux #(
  parameter int MAX_COUNT      = 16_000_000,
  parameter int DIGITS         = 4,
  parameter int SCAN_COUNT     = 16_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [6:0]            led_out,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  wrap
);

  localparam int PW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(MAX_COUNT - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_COUNT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [PW-1:0]            prescaler;
  logic [DIGITS-1:0][3:0]   digit;
  logic [DIGITS-1:0][3:0]   digit_nxt;
  logic [DIGITS-1:0][3:0]   load_clamped;
  logic [DIGITS-1:0]        blank;
  logic                     step;
  logic                     carry;
  logic                     wrap_nxt;
  logic                     zero_above;
  logic [SW-1:0]            scan_cnt;
  logic [IW-1:0]            scan_idx;
  logic                     out_en;
  logic [3:0]               cur_digit;

  // Active-high gfedcba pattern for one BCD digit.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b0000000;
    endcase
  endfunction

  assign step    = enable && (prescaler == PRE_LAST);
  assign bcd_out = digit;

  // Ripple increment/decrement; the carry out of the top digit is the wrap condition.
  always_comb begin
    digit_nxt = digit;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (up_down) begin
          carry        = (digit[i] == 4'd9);
          digit_nxt[i] = carry ? 4'd0 : digit[i] + 4'd1;
        end else begin
          carry        = (digit[i] == 4'd0);
          digit_nxt[i] = carry ? 4'd9 : digit[i] - 4'd1;
        end
      end
    end
    wrap_nxt = carry;
  end

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[i] = (load_value[4*i +: 4] > 4'd9) ? 4'd9 : load_value[4*i +: 4];
    end
  end

  // A digit is blank when it and every digit above it is zero; digit 0 always shows.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (digit[i] == 4'd0);
      blank[i]   = BLANK_LZ && (i != 0) && zero_above;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      digit     <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        digit     <= load_clamped;
        prescaler <= '0;
      end else if (step) begin
        digit     <= digit_nxt;
        prescaler <= '0;
        wrap      <= wrap_nxt;
      end else if (enable) begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign cur_digit = digit[scan_idx];

  // out_en holds the display dark for the first edge after reset release,
  // so the first lit digit appears on the second edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_en    <= 1'b0;
      digit_sel <= '0;
      led_out   <= SEG_OFF;
    end else begin
      out_en <= 1'b1;
      if (out_en) begin
        digit_sel <= DIGITS'(1) << scan_idx;
        led_out   <= blank[scan_idx] ? SEG_OFF
                   : (SEG_ACTIVE_LOW ? ~decode(cur_digit) : decode(cur_digit));
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit_chk
    assert property (@(posedge clk) disable iff (!reset) digit[g] <= 4'd9);
  end
  assert property (@(posedge clk) disable iff (!reset) $onehot0(digit_sel));
  assert property (@(posedge clk) disable iff (!reset) prescaler <= PRE_LAST);
  assert property (@(posedge clk) !reset |=> led_out == SEG_OFF);

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
module tb_seven_segment_counter_mux;

  localparam int N  = 3;
  localparam int D0 = 2, M0 = 4, S0 = 1;
  localparam int D1 = 4, M1 = 5, S1 = 2;
  localparam int D2 = 1, M2 = 2, S2 = 3;

  int p_dig  [N] = '{D0, D1, D2};
  int p_max  [N] = '{M0, M1, M2};
  int p_scan [N] = '{S0, S1, S2};
  bit p_low  [N] = '{1'b1, 1'b1, 1'b0};
  bit p_blz  [N] = '{1'b0, 1'b1, 1'b1};

  logic [6:0] seg_tbl [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, up_down = 1'b1, load = 1'b0;
  logic [31:0] lv = '0;

  logic [6:0]  led0, led1, led2;
  logic [1:0]  sel0;
  logic [3:0]  sel1;
  logic [0:0]  sel2;
  logic [7:0]  bcd0;
  logic [15:0] bcd1;
  logic [3:0]  bcd2;
  logic        wrap0, wrap1, wrap2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seven_segment_counter_mux #(.MAX_COUNT(M0), .DIGITS(D0), .SCAN_COUNT(S0),
                              .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv[4*D0-1:0]), .led_out(led0), .digit_sel(sel0), .bcd_out(bcd0), .wrap(wrap0));

  seven_segment_counter_mux #(.MAX_COUNT(M1), .DIGITS(D1), .SCAN_COUNT(S1),
                              .SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv[4*D1-1:0]), .led_out(led1), .digit_sel(sel1), .bcd_out(bcd1), .wrap(wrap1));

  seven_segment_counter_mux #(.MAX_COUNT(M2), .DIGITS(D2), .SCAN_COUNT(S2),
                              .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(lv[4*D2-1:0]), .led_out(led2), .digit_sel(sel2), .bcd_out(bcd2), .wrap(wrap2));

  logic [31:0] a_bcd [N];
  logic [31:0] a_sel [N];
  logic [6:0]  a_led [N];
  logic        a_wrap[N];
  assign a_bcd[0] = {24'b0, bcd0}; assign a_sel[0] = {30'b0, sel0}; assign a_led[0] = led0; assign a_wrap[0] = wrap0;
  assign a_bcd[1] = {16'b0, bcd1}; assign a_sel[1] = {28'b0, sel1}; assign a_led[1] = led1; assign a_wrap[1] = wrap1;
  assign a_bcd[2] = {28'b0, bcd2}; assign a_sel[2] = {31'b0, sel2}; assign a_led[2] = led2; assign a_wrap[2] = wrap2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: count held as a plain integer ----------------
  int          m_cnt  [N];
  int          m_presc[N];
  int          m_sc   [N];
  int          m_idx  [N];
  bit          m_oen  [N];
  bit          m_wrap [N];
  logic [31:0] m_sel  [N];
  logic [6:0]  m_led  [N];

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r *= 10;
    return r;
  endfunction

  function automatic int dig_of(input int v, input int i);
    return (v / pow10(i)) % 10;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'(dig_of(v, i));
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int k, input int v, input int i);
    logic [6:0] pat;
    pat = (p_blz[k] && i > 0 && v < pow10(i)) ? 7'b0000000 : seg_tbl[dig_of(v, i)];
    return p_low[k] ? ~pat : pat;
  endfunction

  function automatic int clamp_load(input int k);
    int v = 0;
    int nib;
    for (int i = 0; i < p_dig[k]; i++) begin
      nib = int'(lv[4*i +: 4]);
      if (nib > 9) nib = 9;
      v += nib * pow10(i);
    end
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < N; k++) begin
      if (!reset) begin
        m_cnt[k] = 0; m_presc[k] = 0; m_sc[k] = 0; m_idx[k] = 0;
        m_oen[k] = 0; m_wrap[k] = 0; m_sel[k] = '0;
        m_led[k] = p_low[k] ? 7'h7F : 7'h00;
      end else begin
        int modv;
        modv = pow10(p_dig[k]);
        if (m_oen[k]) begin
          m_sel[k] = 32'(1) << m_idx[k];
          m_led[k] = seg_of(k, m_cnt[k], m_idx[k]);
        end
        m_oen[k]  = 1;
        m_wrap[k] = 0;
        if (load) begin
          m_cnt[k]   = clamp_load(k);
          m_presc[k] = 0;
        end else if (enable) begin
          if (m_presc[k] == p_max[k] - 1) begin
            m_presc[k] = 0;
            if (up_down) begin
              m_wrap[k] = (m_cnt[k] == modv - 1);
              m_cnt[k]  = (m_cnt[k] + 1) % modv;
            end else begin
              m_wrap[k] = (m_cnt[k] == 0);
              m_cnt[k]  = (m_cnt[k] + modv - 1) % modv;
            end
          end else begin
            m_presc[k]++;
          end
        end
        if (m_sc[k] == p_scan[k] - 1) begin
          m_sc[k]  = 0;
          m_idx[k] = (m_idx[k] + 1) % p_dig[k];
        end else begin
          m_sc[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      check($sformatf("bcd%0d", k),  a_bcd[k],  to_bcd(m_cnt[k], p_dig[k]));
      check($sformatf("wrap%0d", k), 32'(a_wrap[k]), 32'(m_wrap[k]));
      check($sformatf("sel%0d", k),  a_sel[k],  m_sel[k]);
      check($sformatf("led%0d", k),  32'(a_led[k]), 32'(m_led[k]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    tick(); tick();
    check("rst_bcd0", 32'(bcd0), 32'h0);
    check("rst_led0", 32'(led0), 32'h7F);
    check("rst_sel1", 32'(sel1), 32'h0);
    check("rst_led2", 32'(led2), 32'h0);
    check("rst_wrap0", 32'(wrap0), 32'h0);

    reset = 1'b1;
    tick(); check("start_sel1_edge1", 32'(sel1), 32'h0);
    tick(); check("start_sel1_edge2", 32'(sel1), 32'h1);
    check("start_sel2_edge2", 32'(sel2), 32'h1);

    enable = 1'b1; up_down = 1'b1;
    repeat (420) tick();

    // Static 7 shown with and without leading-zero blanking.
    enable = 1'b0; lv = 32'h7; load = 1'b1; tick(); load = 1'b0; tick();
    for (int c = 0; c < 8; c++) begin
      check("blank_led1", 32'(led1), (sel1 == 4'b0001) ? 32'h78 : 32'h7F);
      check("nolz_led0",  32'(led0), (sel0 == 2'b01) ? 32'h78 : 32'h40);
      check("ahi_led2",   32'(led2), 32'h07);
      tick();
    end

    // Load of F3 coinciding with a step.
    enable = 1'b1; up_down = 1'b1; lv = 32'h0000_00F3;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (m_presc[0] == M0 - 1) found = 1'b1;
      else tick();
    end
    check("align_step", 32'(found), 32'h1);
    load = 1'b1; tick(); load = 1'b0;
    check("load_clamp_bcd0", 32'(bcd0), 32'h93);
    check("load_clamp_bcd1", 32'(bcd1), 32'h0093);
    check("load_wrap0", 32'(wrap0), 32'h0);
    repeat (3) begin tick(); check("load_hold", 32'(bcd0), 32'h93); end
    tick(); check("load_restart", 32'(bcd0), 32'h94);

    // Down counting: borrow and wrap to all nines.
    up_down = 1'b0; lv = 32'h10; load = 1'b1; tick(); load = 1'b0;
    check("down_load", 32'(bcd0), 32'h10);
    repeat (3) begin tick(); check("down_hold", 32'(bcd0), 32'h10); end
    tick(); check("borrow", 32'(bcd0), 32'h09);
    lv = 32'h0; load = 1'b1; tick(); load = 1'b0;
    repeat (4) tick();
    check("down_wrap_bcd", 32'(bcd0), 32'h99);
    check("down_wrap_pulse", 32'(wrap0), 32'h1);
    tick(); check("wrap_one_cycle", 32'(wrap0), 32'h0);
    repeat (30) tick();

    // Freeze mid-count.
    up_down = 1'b1; repeat (7) tick();
    enable = 1'b0; repeat (20) tick();
    enable = 1'b1; repeat (20) tick();

    // Asynchronous reset between edges.
    enable = 1'b0; lv = 32'h0042; load = 1'b1; tick(); load = 1'b0; tick(); tick();
    check("pre_arst_bcd1", 32'(bcd1), 32'h0042);
    @(posedge clk); #2 reset = 1'b0; #1;
    check("arst_led1", 32'(led1), 32'h7F);
    check("arst_sel1", 32'(sel1), 32'h0);
    check("arst_bcd1", 32'(bcd1), 32'h0);
    check("arst_bcd0", 32'(bcd0), 32'h0);
    check("arst_led2", 32'(led2), 32'h0);
    tick(); reset = 1'b1;
    tick(); check("rel_sel1_edge1", 32'(sel1), 32'h0);
    tick(); check("rel_sel1_edge2", 32'(sel1), 32'h1);

    // Randomized phase.
    for (int c = 0; c < 4000; c++) begin
      enable = ($urandom_range(9) != 0);
      if ($urandom_range(199) == 0) up_down = ~up_down;
      load = ($urandom_range(49) == 0);
      lv   = $urandom;
      if ($urandom_range(799) == 0) begin
        @(posedge clk); #2 reset = 1'b0;
        tick(); reset = 1'b1;
      end
      tick();
    end

    load = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_counter_mux.md
Name: seven_segment_counter_mux

Overview:
Parametrised multi-digit BCD seconds counter with a time-multiplexed seven-segment driver. It is the successor to the single-digit seconds display. It adds:
- configurable digit count;
- up/down counting;
- synchronous preload;
- optional leading-zero blanking;
- a digit-scan output for common-anode or common-cathode boards.

It sits between the board clock and the display pins, and is fully self-contained.

Parameters:
MAX_COUNT, 16_000_000, clk cycles per count step (prescaler period), ≥2
DIGITS, 4, number of BCD digits, 1..8
SCAN_COUNT, 16_000, clk cycles each digit is held on the display, ≥1
SEG_ACTIVE_LOW, 1, 1: segment lit when bit=0; 0: lit when bit=1
BLANK_LZ, 0, 1: blank leading zeros (digit 0 never blanked)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
enable  input  1  prescaler runs while high; freezes prescaler and count when low
up_down  input  1  1=count up, 0=count down; sampled on each step
load  input  1  synchronous preload strobe
load_value  input  4*DIGITS  BCD preload, digit i at [4i+3:4i]
led_out  output  7  segments {g,f,e,d,c,b,a} of the currently selected digit
digit_sel  output  DIGITS  one-hot, active-high digit enable
bcd_out  output  4*DIGITS  current count, BCD
wrap  output  1  one-cycle pulse on count wrap-around

Behaviour:
- Reset (reset=0, asynchronous):
  - prescaler=0, all digits=0, scan index=0, scan counter=0;
  - digit_sel=0;
  - led_out = all off (7'b1111111 if SEG_ACTIVE_LOW, else 7'b0000000);
  - wrap=0.
- Prescaler counts 0..MAX_COUNT-1 while enable=1. The step pulse fires in the cycle where prescaler==MAX_COUNT-1, and prescaler returns to 0 on the next edge.
- Step, up: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. All digits 9 → all 0, with wrap=1 on the same edge.
- Step, down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit. All digits 0 → all 9, with wrap=1.
- Load has priority over a step in the same cycle:
  - digits take load_value on the next edge;
  - any nibble >9 is clamped to 9;
  - prescaler is cleared to 0;
  - wrap stays 0.
- Every digit is ≤9 at all times; bcd_out mirrors the digit registers directly.
- Scan counter runs independently of enable, 0..SCAN_COUNT-1. At terminal count the scan index advances i→i+1, and DIGITS-1→0.
- led_out and digit_sel are registered with 1-cycle latency from the scan index and digit state:
  - digit_sel = 1<<scan index;
  - led_out = decode(digit[scan index]).
  - First valid output is on the 2nd rising edge after reset deasserts.
- Decode, active-high gfedcba:
  0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110,
  5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  SEG_ACTIVE_LOW inverts all bits.
- BLANK_LZ=1: digit i>0 is blank (all off) when it and all higher digits are 0. digit_sel still asserts for a blanked digit.
- DIGITS=1: scan index is constant 0 and digit_sel is constant 1 after reset.
- Reset mid-count or mid-scan aborts immediately to reset values. No wrap pulse is produced.
- enable=0 holds the prescaler and digits; load still works.

Test Plan:
- DIGITS=2, MAX_COUNT=4, up=1, enable=1 from reset → bcd_out steps 00,01,…,99 every 4 cycles; 99→00 with wrap high exactly 1 cycle; no other wrap.
- Same config, up_down=0 from 00 → next step gives 99 with wrap=1, then 98; borrow 10→09 is correct.
- load=1 with load_value=8'hF3 in the same cycle as a step → bcd_out=8'h93, prescaler restarts (next step 4 cycles later), wrap=0.
- DIGITS=4, SCAN_COUNT=2, count=0007, BLANK_LZ=1, SEG_ACTIVE_LOW=1 → digit_sel cycles 0001,0010,0100,1000 every 2 cycles; led_out=7'b1111000 on digit 0 and 7'b1111111 on digits 1–3; with BLANK_LZ=0 digits 1–3 show 7'b1000000.
- Assert reset asynchronously between edges at count 0042 → led_out all-off and digit_sel=0 without waiting for a clock edge; bcd_out=0; after release the first valid digit_sel=0001 appears on the 2nd edge.
- enable=0 for 20 cycles mid-count → bcd_out and prescaler frozen while scanning continues; on resume the step arrives after the remaining prescaler cycles.
- Formal properties, checked throughout:
  - every digit ≤9;
  - digit_sel is one-hot or zero;
  - prescaler ≤MAX_COUNT-1;
  - reset |=> led_out all-off.
